// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Package : alu_seq_pkg
// Brief   : Shared constants for the ALU operation sequencer: R-type funct
//           codes, ALU {sel1,sel0} encodings and the sequencer FSM states.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  // R-type funct codes understood by the sequencer
  localparam logic [5:0] c_funct_add = 6'h20;
  localparam logic [5:0] c_funct_sub = 6'h22;
  localparam logic [5:0] c_funct_and = 6'h24;
  localparam logic [5:0] c_funct_or  = 6'h25;
  localparam logic [5:0] c_funct_slt = 6'h2A;

  // ALU result-select encoding {sel1,sel0}
  localparam logic [1:0] c_sel_and  = 2'b00;
  localparam logic [1:0] c_sel_or   = 2'b01;
  localparam logic [1:0] c_sel_add  = 2'b10;
  localparam logic [1:0] c_sel_less = 2'b11;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_SLT2 = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage : alu_seq_pkg

`default_nettype wire

// File: rtl/alu_funct_dec.sv
// ============================================================================
// Module : alu_funct_dec
// Brief  : Combinational funct decoder producing first-pass ALU controls,
//          a two-pass flag (SLT) and an unsupported-funct error flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_funct_dec
  import alu_seq_pkg::*;
#(
  parameter int FUNCT_W = 6
) (
  input  logic [FUNCT_W-1:0] funct_i,
  output logic [1:0]         sel_o,
  output logic               binv_o,
  output logic               cin_o,
  output logic               two_pass_o,
  output logic               err_o
);

  // Map funct to first-pass ALU controls; unknown codes leave the ALU idle
  always_comb begin
    sel_o      = c_sel_and;
    binv_o     = 1'b0;
    cin_o      = 1'b0;
    two_pass_o = 1'b0;
    err_o      = 1'b0;
    case (funct_i)
      FUNCT_W'(c_funct_add): sel_o = c_sel_add;
      FUNCT_W'(c_funct_sub): begin
        sel_o  = c_sel_add;
        binv_o = 1'b1;
        cin_o  = 1'b1;
      end
      FUNCT_W'(c_funct_and): sel_o = c_sel_and;
      FUNCT_W'(c_funct_or):  sel_o = c_sel_or;
      FUNCT_W'(c_funct_slt): begin
        // Pass 1 is a subtraction; the set bit is derived from it
        sel_o      = c_sel_add;
        binv_o     = 1'b1;
        cin_o      = 1'b1;
        two_pass_o = 1'b1;
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule : alu_funct_dec

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module : alu_op_sequencer
// Brief  : Multi-cycle issuer for the 32-bit datapath ALU. Accepts a funct and
//          operands over valid/ready, drives the ALU controls from registers,
//          captures result/carry and returns a registered response. SLT takes
//          two ALU passes (SUB, then LESS-select with the computed set bit).
//          Optional macro ALU_OVF_EN adds the resp_ovf output (signed
//          overflow of ADD/SUB).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [FUNCT_W-1:0] req_funct,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WIDTH-1:0]   resp_result,
  output logic               resp_co,
  output logic               resp_err,
`ifdef ALU_OVF_EN
  output logic               resp_ovf,
`endif
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic               alu_cin,
  output logic               alu_binv,
  output logic [WIDTH-1:0]   alu_less,
  output logic               alu_sel1,
  output logic               alu_sel0,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_co
);

  state_e state_q, state_d;

  // Latched request attributes
  logic two_pass_q, two_pass_d;
  logic err_q,      err_d;
  logic logic_q,    logic_d;     // AND/OR: carry-out reported as 0
`ifdef ALU_OVF_EN
  logic arith_q,    arith_d;     // single-pass ADD/SUB: overflow reported
  logic resp_ovf_q, resp_ovf_d;
`endif

  // Registered ALU drive
  logic [WIDTH-1:0] alu_a_q,    alu_a_d;
  logic [WIDTH-1:0] alu_b_q,    alu_b_d;
  logic [WIDTH-1:0] alu_less_q, alu_less_d;
  logic [1:0]       alu_sel_q,  alu_sel_d;
  logic             alu_cin_q,  alu_cin_d;
  logic             alu_binv_q, alu_binv_d;

  // Registered response
  logic             resp_valid_q,  resp_valid_d;
  logic [WIDTH-1:0] resp_result_q, resp_result_d;
  logic             resp_co_q,     resp_co_d;
  logic             resp_err_q,    resp_err_d;

  // Decoder outputs for the incoming funct
  logic [1:0] dec_sel;
  logic       dec_binv;
  logic       dec_cin;
  logic       dec_two_pass;
  logic       dec_err;

  alu_funct_dec #(
    .FUNCT_W (FUNCT_W)
  ) u_dec (
    .funct_i    (req_funct),
    .sel_o      (dec_sel),
    .binv_o     (dec_binv),
    .cin_o      (dec_cin),
    .two_pass_o (dec_two_pass),
    .err_o      (dec_err)
  );

  // Signed overflow of the current adder pass, using the effective (possibly
  // inverted) B operand so the same expression covers ADD, SUB and SLT pass 1.
  logic b_eff_msb;
  logic pass_ovf;
  logic slt_set;

  assign b_eff_msb = alu_b_q[WIDTH-1] ^ alu_binv_q;
  assign pass_ovf  = (alu_a_q[WIDTH-1] == b_eff_msb) &&
                     (alu_result[WIDTH-1] != alu_a_q[WIDTH-1]);
  assign slt_set   = alu_result[WIDTH-1] ^ pass_ovf;

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      two_pass_q    <= 1'b0;
      err_q         <= 1'b0;
      logic_q       <= 1'b0;
`ifdef ALU_OVF_EN
      arith_q       <= 1'b0;
      resp_ovf_q    <= 1'b0;
`endif
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_less_q    <= '0;
      alu_sel_q     <= 2'b00;
      alu_cin_q     <= 1'b0;
      alu_binv_q    <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= '0;
      resp_co_q     <= 1'b0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      two_pass_q    <= two_pass_d;
      err_q         <= err_d;
      logic_q       <= logic_d;
`ifdef ALU_OVF_EN
      arith_q       <= arith_d;
      resp_ovf_q    <= resp_ovf_d;
`endif
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_less_q    <= alu_less_d;
      alu_sel_q     <= alu_sel_d;
      alu_cin_q     <= alu_cin_d;
      alu_binv_q    <= alu_binv_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_co_q     <= resp_co_d;
      resp_err_q    <= resp_err_d;
    end
  end

  // Next-state, ALU drive and response capture; ALU drive defaults to zero
  always_comb begin
    state_d       = state_q;
    two_pass_d    = two_pass_q;
    err_d         = err_q;
    logic_d       = logic_q;
`ifdef ALU_OVF_EN
    arith_d       = arith_q;
    resp_ovf_d    = resp_ovf_q;
`endif
    alu_a_d       = '0;
    alu_b_d       = '0;
    alu_less_d    = '0;
    alu_sel_d     = 2'b00;
    alu_cin_d     = 1'b0;
    alu_binv_d    = 1'b0;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    resp_co_d     = resp_co_q;
    resp_err_d    = resp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d    = ST_EXEC;
          two_pass_d = dec_two_pass;
          err_d      = dec_err;
          logic_d    = ~dec_sel[1];
`ifdef ALU_OVF_EN
          arith_d    = ~dec_err & ~dec_two_pass & (dec_sel == c_sel_add);
`endif
          // Unsupported funct keeps the ALU inputs at zero
          if (!dec_err) begin
            alu_a_d    = req_a;
            alu_b_d    = req_b;
            alu_sel_d  = dec_sel;
            alu_binv_d = dec_binv;
            alu_cin_d  = dec_cin;
          end
        end
      end

      ST_EXEC: begin
        if (two_pass_q && !err_q) begin
          // Second SLT pass: select the LESS input carrying the set bit
          state_d    = ST_SLT2;
          alu_a_d    = alu_a_q;
          alu_b_d    = alu_b_q;
          alu_sel_d  = c_sel_less;
          alu_less_d = {{(WIDTH-1){1'b0}}, slt_set};
        end else begin
          state_d       = ST_DONE;
          resp_valid_d  = 1'b1;
          resp_err_d    = err_q;
          resp_result_d = err_q ? '0 : alu_result;
          resp_co_d     = (err_q || logic_q) ? 1'b0 : alu_co;
`ifdef ALU_OVF_EN
          resp_ovf_d    = arith_q & pass_ovf;
`endif
        end
      end

      ST_SLT2: begin
        state_d       = ST_DONE;
        resp_valid_d  = 1'b1;
        resp_err_d    = 1'b0;
        resp_result_d = alu_result;
        resp_co_d     = alu_co;
`ifdef ALU_OVF_EN
        resp_ovf_d    = 1'b0;
`endif
      end

      ST_DONE: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_co     = resp_co_q;
  assign resp_err    = resp_err_q;
`ifdef ALU_OVF_EN
  assign resp_ovf    = resp_ovf_q;
`endif
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_less    = alu_less_q;
  assign alu_sel1    = alu_sel_q[1];
  assign alu_sel0    = alu_sel_q[0];
  assign alu_cin     = alu_cin_q;
  assign alu_binv    = alu_binv_q;

endmodule : alu_op_sequencer

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ============================================================================
// Module : tb_alu_op_sequencer
// Brief  : Directed self-checking bench for alu_op_sequencer with a
//          behavioural 32-bit ALU attached to its alu_* interface.
//          Honours ALU_OVF_EN when defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_op_sequencer;

  localparam int WIDTH   = 32;
  localparam int FUNCT_W = 6;

  logic               clk;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic [FUNCT_W-1:0] req_funct;
  logic [WIDTH-1:0]   req_a;
  logic [WIDTH-1:0]   req_b;
  logic               resp_valid;
  logic               resp_ready;
  logic [WIDTH-1:0]   resp_result;
  logic               resp_co;
  logic               resp_err;
`ifdef ALU_OVF_EN
  logic               resp_ovf;
`endif
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic               alu_cin;
  logic               alu_binv;
  logic [WIDTH-1:0]   alu_less;
  logic               alu_sel1;
  logic               alu_sel0;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_co;

  int n_cmp = 0;
  int n_err = 0;

  alu_op_sequencer #(
    .WIDTH   (WIDTH),
    .FUNCT_W (FUNCT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_funct   (req_funct),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_co     (resp_co),
    .resp_err    (resp_err),
`ifdef ALU_OVF_EN
    .resp_ovf    (resp_ovf),
`endif
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_cin     (alu_cin),
    .alu_binv    (alu_binv),
    .alu_less    (alu_less),
    .alu_sel1    (alu_sel1),
    .alu_sel0    (alu_sel0),
    .alu_result  (alu_result),
    .alu_co      (alu_co)
  );

  // Behavioural datapath ALU: AND / OR / ADD / LESS with B-invert and carry-in
  logic [WIDTH-1:0] alu_beff;
  logic [WIDTH:0]   alu_sum;
  always_comb begin
    alu_beff = alu_binv ? ~alu_b : alu_b;
    alu_sum  = {1'b0, alu_a} + {1'b0, alu_beff} + {{WIDTH{1'b0}}, alu_cin};
    alu_co   = alu_sum[WIDTH];
    case ({alu_sel1, alu_sel0})
      2'b00:   alu_result = alu_a & alu_beff;
      2'b01:   alu_result = alu_a | alu_beff;
      2'b10:   alu_result = alu_sum[WIDTH-1:0];
      default: alu_result = alu_less;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for the response, leave it pending.
  // lat counts rising edges from the accepting edge up to resp_valid.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [3:0] exec_ctl,
                       output logic [31:0] slt2_less);
    @(negedge clk);
    req_valid = 1'b1;
    req_funct = f;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat       = 1;
    exec_ctl  = {alu_sel1, alu_sel0, alu_binv, alu_cin};
    slt2_less = 32'h0;
    while (!resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 2) slt2_less = alu_less;
    end
  endtask

  // Accept the pending response and check the return to IDLE
  task automatic accept(input string tag);
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk({tag, "_vld_drop"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, "_rdy_back"}, {31'b0, req_ready}, 32'd1);
  endtask

  int          lat;
  logic [3:0]  ctl;
  logic [31:0] less;

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_funct  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready",  {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_result",     resp_result, 32'd0);
    chk("rst_co_err",     {30'b0, resp_co, resp_err}, 32'd0);
    chk("rst_alu_ab",     alu_a | alu_b | alu_less, 32'd0);
    chk("rst_alu_ctl",    {28'b0, alu_sel1, alu_sel0, alu_binv, alu_cin}, 32'd0);
`ifdef ALU_OVF_EN
    chk("rst_ovf",        {31'b0, resp_ovf}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // ---- ADD 0x7FFFFFFF + 1 ----
    issue(6'h20, 32'h7FFF_FFFF, 32'h0000_0001, lat, ctl, less);
    chk("add_lat",    lat, 32'd2);
    chk("add_ctl",    {28'b0, ctl}, 32'h8);
    chk("add_result", resp_result, 32'h8000_0000);
    chk("add_co_err", {30'b0, resp_co, resp_err}, 32'd0);
`ifdef ALU_OVF_EN
    chk("add_ovf",    {31'b0, resp_ovf}, 32'd1);
`endif
    chk("add_busy",   {31'b0, req_ready}, 32'd0);
    accept("add");

    // ---- SUB 5 - 5 ----
    issue(6'h22, 32'd5, 32'd5, lat, ctl, less);
    chk("sub_lat",    lat, 32'd2);
    chk("sub_ctl",    {28'b0, ctl}, 32'hB);
    chk("sub_result", resp_result, 32'd0);
    chk("sub_co",     {31'b0, resp_co}, 32'd1);
`ifdef ALU_OVF_EN
    chk("sub_ovf",    {31'b0, resp_ovf}, 32'd0);
`endif
    accept("sub");

    // ---- AND ----
    issue(6'h24, 32'hF0F0_F0F0, 32'h0FF0_0FF0, lat, ctl, less);
    chk("and_lat",    lat, 32'd2);
    chk("and_ctl",    {28'b0, ctl}, 32'h0);
    chk("and_result", resp_result, 32'h00F0_00F0);
    chk("and_co",     {31'b0, resp_co}, 32'd0);
    accept("and");

    // ---- OR ----
    issue(6'h25, 32'hF0F0_F0F0, 32'h0FF0_0FF0, lat, ctl, less);
    chk("or_ctl",     {28'b0, ctl}, 32'h4);
    chk("or_result",  resp_result, 32'hFFF0_FFF0);
    chk("or_co",      {31'b0, resp_co}, 32'd0);
    accept("or");

    // ---- SLT -1 < 1 ----
    issue(6'h2A, 32'hFFFF_FFFF, 32'h0000_0001, lat, ctl, less);
    chk("slt1_lat",    lat, 32'd3);
    chk("slt1_ctl",    {28'b0, ctl}, 32'hB);
    chk("slt1_less",   less, 32'd1);
    chk("slt1_result", resp_result, 32'd1);
    chk("slt1_co_err", {30'b0, resp_co, resp_err}, 32'h2);
    accept("slt1");

    // ---- SLT 0x80000000 < 1 (pass-1 overflow) ----
    issue(6'h2A, 32'h8000_0000, 32'h0000_0001, lat, ctl, less);
    chk("slt2_lat",    lat, 32'd3);
    chk("slt2_result", resp_result, 32'd1);
    chk("slt2_co",     {31'b0, resp_co}, 32'd0);
`ifdef ALU_OVF_EN
    chk("slt2_ovf",    {31'b0, resp_ovf}, 32'd0);
`endif
    accept("slt2");

    // ---- SLT 1 < -1 is false ----
    issue(6'h2A, 32'h0000_0001, 32'hFFFF_FFFF, lat, ctl, less);
    chk("slt3_less",   less, 32'd0);
    chk("slt3_result", resp_result, 32'd0);
    chk("slt3_co",     {31'b0, resp_co}, 32'd1);
    accept("slt3");

    // ---- unsupported funct, response held while resp_ready low ----
    issue(6'h27, 32'h1234_5678, 32'h9ABC_DEF0, lat, ctl, less);
    chk("err_lat",    lat, 32'd2);
    chk("err_ctl",    {28'b0, ctl}, 32'h0);
    chk("err_flag",   {31'b0, resp_err}, 32'd1);
    chk("err_result", resp_result, 32'd0);
    req_valid = 1'b1;
    req_funct = 6'h20;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_state", {29'b0, resp_valid, resp_err, req_ready}, 32'h6);
      chk("hold_result", resp_result, 32'd0);
    end
    req_valid = 1'b0;
    accept("err");

    // ---- reset during EXEC of SLT ----
    @(negedge clk);
    req_valid = 1'b1;
    req_funct = 6'h2A;
    req_a     = 32'hFFFF_FFFF;
    req_b     = 32'h0000_0001;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("midop_in_exec", {31'b0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midop_rst_state", {30'b0, resp_valid, req_ready}, 32'd1);
    chk("midop_rst_alu",   {28'b0, alu_sel1, alu_sel0, alu_binv, alu_cin}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("midop_no_resp", {30'b0, resp_valid, req_ready}, 32'd1);
    end
    issue(6'h20, 32'd2, 32'd3, lat, ctl, less);
    chk("post_add_lat",    lat, 32'd2);
    chk("post_add_result", resp_result, 32'd5);
    chk("post_add_co",     {31'b0, resp_co}, 32'd0);
    accept("post_add");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule : tb_alu_op_sequencer

`default_nettype wire
